// File: rtl/and_seq_gen.sv
// ---------------------------------------------------------------------------
// and_seq_gen
//
// Purpose:
//   Stimulus generator for the 13-state AND sequence detector. It plays the
//   12-step {i4,i3,i2,i1} pattern that the detector accepts. Each step is held
//   for a fixed number of dwell ticks, so the detector ends in its terminal
//   state.
//
//   Timing, counted from the edge E that accepts start:
//     - LEAD_TICKS ticks of all-zero outputs follow E.
//     - Steps 1..12 are then played in order.
//     - On the edge where the dwell of step 12 expires, done pulses for one
//       cycle and all outputs return to zero.
//   All outputs are registered.
//
// Parameters:
//   TICK_CYCLES  clocks per dwell tick (>= 1; a value of 1 makes every clock a tick)
//   LEAD_TICKS   all-zero ticks between start acceptance and step 1 (>= 1)
//   FINAL_TICKS  ticks that step 12 is held before done (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        run request; sampled only while idle
//   abort        synchronous cancel; returns to idle on the next edge
//   i1..i4       pattern bits to the detector inputs
//   busy         high while the lead-in or the pattern is running
//   done         one-cycle pulse when a run completes
//   step         current step: 0 when idle or in the lead-in, 1..12 while playing
//
// Optional build macro:
//   AND_SEQ_GEN_LOOP_EN  when defined, a completed run pulses done and goes
//                        straight back into the lead-in. The pattern then
//                        repeats until abort or reset, and start is ignored
//                        while looping.
// ---------------------------------------------------------------------------
module and_seq_gen #(
  parameter int TICK_CYCLES = 10,
  parameter int LEAD_TICKS  = 2,
  parameter int FINAL_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       i1,
  output logic       i2,
  output logic       i3,
  output logic       i4,
  output logic       busy,
  output logic       done,
  output logic [3:0] step
);

  localparam int PRESC_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  // The longest dwell in the fixed table is 5 ticks.
  localparam int MAX_TICKS = (LEAD_TICKS > FINAL_TICKS)
                             ? ((LEAD_TICKS > 5) ? LEAD_TICKS : 5)
                             : ((FINAL_TICKS > 5) ? FINAL_TICKS : 5);
  localparam int DWELL_W   = $clog2(MAX_TICKS + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [3:0]         LAST_STEP  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [3:0]           step_q,  step_d;
  logic [3:0]           vec_q,   vec_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;

  logic                 tick;
  logic [DWELL_W-1:0]   dwell_tgt;
  logic                 expire;

  // Pattern vector {i4,i3,i2,i1} for step k.
  function automatic logic [3:0] step_vec(input logic [3:0] k);
    case (k)
      4'd1:    step_vec = 4'b0100;
      4'd2:    step_vec = 4'b1101;
      4'd3:    step_vec = 4'b1001;
      4'd4:    step_vec = 4'b1100;
      4'd5:    step_vec = 4'b0110;
      4'd6:    step_vec = 4'b0111;
      4'd7:    step_vec = 4'b1111;
      4'd8:    step_vec = 4'b0011;
      4'd9:    step_vec = 4'b1010;
      4'd10:   step_vec = 4'b1100;
      4'd11:   step_vec = 4'b0101;
      4'd12:   step_vec = 4'b0001;
      default: step_vec = 4'b0000;
    endcase
  endfunction

  // Dwell ticks for step k. Step 12 is held for FINAL_TICKS.
  function automatic logic [DWELL_W-1:0] step_dwell(input logic [3:0] k);
    case (k)
      4'd1:    step_dwell = DWELL_W'(5);
      4'd2:    step_dwell = DWELL_W'(2);
      4'd3:    step_dwell = DWELL_W'(4);
      4'd4:    step_dwell = DWELL_W'(5);
      4'd5:    step_dwell = DWELL_W'(5);
      4'd6:    step_dwell = DWELL_W'(5);
      4'd7:    step_dwell = DWELL_W'(3);
      4'd8:    step_dwell = DWELL_W'(3);
      4'd9:    step_dwell = DWELL_W'(2);
      4'd10:   step_dwell = DWELL_W'(2);
      4'd11:   step_dwell = DWELL_W'(3);
      4'd12:   step_dwell = DWELL_W'(FINAL_TICKS);
      default: step_dwell = DWELL_W'(1);
    endcase
  endfunction

  // The prescaler is held at zero while idle. It therefore starts counting
  // from the accepting edge, and the first tick lands exactly TICK_CYCLES
  // clocks later.
  assign tick      = (presc_q == PRESC_LAST);
  assign dwell_tgt = (state_q == LEAD) ? DWELL_W'(LEAD_TICKS) : step_dwell(step_q);
  // A phase ends on the tick that completes its dwell count.
  assign expire    = tick && (dwell_q == (dwell_tgt - DWELL_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      dwell_q <= '0;
      step_q  <= 4'd0;
      vec_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      step_q  <= step_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dwell_d = dwell_q;
    step_d  = step_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (abort) begin
      // Abort wins over start and over dwell expiry, including the final
      // expiry, so an aborted run never reports done.
      state_d = IDLE;
      presc_d = '0;
      dwell_d = '0;
      step_d  = 4'd0;
      vec_d   = 4'b0000;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          dwell_d = '0;
          if (start) begin
            state_d = LEAD;
            busy_d  = 1'b1;
          end
        end

        LEAD, PLAY: begin
          presc_d = tick ? '0 : presc_q + PRESC_W'(1);
          if (tick) begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
          if (expire) begin
            dwell_d = '0;
            if (state_q == LEAD) begin
              state_d = PLAY;
              step_d  = 4'd1;
              vec_d   = step_vec(4'd1);
            end else if (step_q != LAST_STEP) begin
              // The step index and its vector change on the same edge.
              step_d  = step_q + 4'd1;
              vec_d   = step_vec(step_q + 4'd1);
            end else begin
              done_d  = 1'b1;
              step_d  = 4'd0;
              vec_d   = 4'b0000;
`ifdef AND_SEQ_GEN_LOOP_EN
              state_d = LEAD;
`else
              state_d = IDLE;
              busy_d  = 1'b0;
`endif
            end
          end
        end

        default: begin
          state_d = IDLE;
          presc_d = '0;
          dwell_d = '0;
          step_d  = 4'd0;
          vec_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign {i4, i3, i2, i1} = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign step             = step_q;

endmodule

// File: tb/tb_and_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_and_seq_gen
//
// Two generators share one stimulus stream:
//   - instance 0 runs with TICK_CYCLES = 1;
//   - instance 1 runs with the default TICK_CYCLES = 10.
// A behavioural model tracks each instance as "cycles since start
// acceptance". The expected step and vector are derived from the dwell table
// by cumulative sums. Every cycle, both instances are checked against the
// model. Directed steps add fixed-value checks at the interesting edges.
// ---------------------------------------------------------------------------
module tb_and_seq_gen;

  localparam int LEAD  = 2;
  localparam int FINAL = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  logic       a_i1, a_i2, a_i3, a_i4, a_busy, a_done;
  logic [3:0] a_step;
  logic       b_i1, b_i2, b_i3, b_i4, b_busy, b_done;
  logic [3:0] b_step;

  and_seq_gen #(.TICK_CYCLES(1), .LEAD_TICKS(LEAD), .FINAL_TICKS(FINAL)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .i1(a_i1), .i2(a_i2), .i3(a_i3), .i4(a_i4),
    .busy(a_busy), .done(a_done), .step(a_step)
  );

  and_seq_gen dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .i1(b_i1), .i2(b_i2), .i3(b_i3), .i4(b_i4),
    .busy(b_busy), .done(b_done), .step(b_step)
  );

  logic [3:0] o_step [2];
  logic [3:0] o_vec  [2];
  logic       o_busy [2];
  logic       o_done [2];

  assign o_step[0] = a_step;
  assign o_vec[0]  = {a_i4, a_i3, a_i2, a_i1};
  assign o_busy[0] = a_busy;
  assign o_done[0] = a_done;
  assign o_step[1] = b_step;
  assign o_vec[1]  = {b_i4, b_i3, b_i2, b_i1};
  assign o_busy[1] = b_busy;
  assign o_done[1] = b_done;

  int checks = 0;
  int errors = 0;

  // Pattern and dwell tables as listed for the detector sequence.
  int         dw [11] = '{5, 2, 4, 5, 5, 5, 3, 3, 2, 2, 3};
  logic [3:0] vt [12] = '{4'b0100, 4'b1101, 4'b1001, 4'b1100, 4'b0110, 4'b0111,
                          4'b1111, 4'b0011, 4'b1010, 4'b1100, 4'b0101, 4'b0001};
  int         tcv [2] = '{1, 10};

  bit m_busy [2];
  bit m_done [2];
  int m_t    [2];

  function automatic int run_ticks();
    int s;
    s = LEAD + FINAL;
    for (int k = 0; k < 11; k++) s += dw[k];
    return s;
  endfunction

  // Expected step and vector, t clocks after start acceptance.
  function automatic void model_out(input int t, input int tc,
                                    output logic [3:0] st, output logic [3:0] v);
    int ticks;
    int onset;
    ticks = t / tc;
    onset = LEAD;
    st = 4'd0;
    v  = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      if (ticks >= onset) begin
        st = 4'(k);
        v  = vt[k-1];
      end
      if (k <= 11) onset += dw[k-1];
    end
  endfunction

  function automatic void model_edge();
    for (int d = 0; d < 2; d++) begin
      if (abort) begin
        m_busy[d] = 1'b0;
        m_done[d] = 1'b0;
      end else if (!m_busy[d]) begin
        m_done[d] = 1'b0;
        if (start) begin
          m_busy[d] = 1'b1;
          m_t[d]    = 0;
        end
      end else begin
        m_t[d]++;
        if (m_t[d] == run_ticks() * tcv[d]) begin
          m_done[d] = 1'b1;
`ifdef AND_SEQ_GEN_LOOP_EN
          m_t[d]    = 0;
`else
          m_busy[d] = 1'b0;
`endif
        end else begin
          m_done[d] = 1'b0;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_done[d] = 1'b0;
      m_t[d]    = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string where);
    logic [3:0] es;
    logic [3:0] ev;
    for (int d = 0; d < 2; d++) begin
      es = 4'd0;
      ev = 4'b0000;
      if (m_busy[d]) model_out(m_t[d], tcv[d], es, ev);
      chk($sformatf("%s_d%0d_step", where, d), 32'(o_step[d]), 32'(es));
      chk($sformatf("%s_d%0d_vec",  where, d), 32'(o_vec[d]),  32'(ev));
      chk($sformatf("%s_d%0d_busy", where, d), 32'(o_busy[d]), 32'(m_busy[d]));
      chk($sformatf("%s_d%0d_done", where, d), 32'(o_done[d]), 32'(m_done[d]));
    end
  endtask

  // One clock: the model follows the edge, and outputs are checked on the
  // falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model("cyc");
    for (int d = 0; d < 2; d++)
      if (m_done[d]) $display("run complete on instance %0d at %0t", d, $time);
  endtask

  // Asynchronous reset between edges. Outputs must clear before any clock.
  task automatic do_reset(input string where);
    #2 reset = 1'b0;
    #1 model_reset();
    check_model(where);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #3 reset = 1'b0;
    #4 check_model("reset_state");
    @(negedge clk);
    reset = 1'b1;
    cyc();
    cyc();

    // Run 1: timing of a full run, with start pulses ignored mid-run.
    $display("run 1: full pattern, start pulses at E+5 and E+30");
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("e0_busy", 32'(a_busy), 32'd1);
`ifdef AND_SEQ_GEN_LOOP_EN
    for (int n = 1; n <= 90; n++) begin
`else
    for (int n = 1; n <= 45; n++) begin
`endif
      if (n == 5 || n == 30) start = 1'b1;
      cyc();
      start = 1'b0;
      if (n == 2) begin
        chk("e2_step", 32'(a_step), 32'd1);
        chk("e2_vec", 32'({a_i4, a_i3, a_i2, a_i1}), 32'b0100);
      end
      if (n == 7) begin
        chk("e7_step", 32'(a_step), 32'd2);
        chk("e7_vec", 32'({a_i4, a_i3, a_i2, a_i1}), 32'b1101);
      end
      if (n == 41) begin
        chk("e41_step", 32'(a_step), 32'd12);
        chk("e41_vec", 32'({a_i4, a_i3, a_i2, a_i1}), 32'b0001);
      end
      if (n == 43) chk("e43_done", 32'(a_done), 32'd0);
      if (n == 44) begin
        chk("e44_done", 32'(a_done), 32'd1);
        chk("e44_vec", 32'({a_i4, a_i3, a_i2, a_i1}), 32'd0);
        chk("e44_step", 32'(a_step), 32'd0);
`ifdef AND_SEQ_GEN_LOOP_EN
        chk("e44_busy", 32'(a_busy), 32'd1);
`else
        chk("e44_busy", 32'(a_busy), 32'd0);
`endif
      end
`ifdef AND_SEQ_GEN_LOOP_EN
      if (n == 46) chk("e46_step", 32'(a_step), 32'd1);
      if (n == 88) chk("e88_done", 32'(a_done), 32'd1);
      if (n == 89) chk("e89_busy", 32'(a_busy), 32'd1);
`endif
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;

    // Run 2: abort during step 5.
    $display("run 2: abort at E+20");
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 20) abort = 1'b1;
      cyc();
      abort = 1'b0;
      if (n == 19) begin
        chk("ab19_step", 32'(a_step), 32'd5);
        chk("ab19_vec", 32'({a_i4, a_i3, a_i2, a_i1}), 32'b0110);
      end
    end
    chk("ab20_step", 32'(a_step), 32'd0);
    chk("ab20_busy", 32'(a_busy), 32'd0);
    chk("ab20_vec", 32'({a_i4, a_i3, a_i2, a_i1}), 32'd0);
    for (int n = 0; n < 50; n++) cyc();

    // Run 3: replay after the abort, then reset mid-run.
    $display("run 3: replay from step 1, reset at E+25");
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      cyc();
      if (n == 2) chk("rp2_step", 32'(a_step), 32'd1);
    end
    do_reset("mid_reset");
    chk("mid_reset_busy", 32'(a_busy), 32'd0);
    for (int n = 0; n < 5; n++) cyc();
    chk("post_reset_step", 32'(a_step), 32'd0);

    // Random phase: sparse start/abort pulses and occasional resets.
    $display("random phase");
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 999) == 0) do_reset("rnd_reset");
      cyc();
    end
    start = 1'b0;
    abort = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
